// File: rtl/riscv_dift_tag_unit.sv
// DIFT tag datapath for the EX stage: programmable per-mode propagation/check
// policy, EX/WB load-tag register, sticky violation exception and counter.
module riscv_dift_tag_unit #(
    parameter int TAG_WIDTH  = 4,
    parameter int MODE_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we_i,
    input  logic [MODE_WIDTH-1:0] cfg_addr_i,
    input  logic [4:0]            cfg_wdata_i,
    output logic [4:0]            cfg_rdata_o,
    input  logic [TAG_WIDTH-1:0]  tag_mask_i,
    input  logic [MODE_WIDTH-1:0] mode_i,
    input  logic [TAG_WIDTH-1:0]  tag_a_i,
    input  logic [TAG_WIDTH-1:0]  tag_b_i,
    input  logic [TAG_WIDTH-1:0]  tag_c_i,
    input  logic                  rf_we_i,
    input  logic                  is_load_i,
    input  logic                  is_store_i,
    input  logic                  branch_i,
    input  logic                  branch_taken_i,
    input  logic                  ex_valid_i,
    input  logic                  wb_ready_i,
    output logic [TAG_WIDTH-1:0]  rf_tag_o,
    output logic                  rf_tag_we_o,
    output logic [TAG_WIDTH-1:0]  mem_tag_o,
    output logic                  mem_tag_we_o,
    output logic [TAG_WIDTH-1:0]  pc_tag_o,
    output logic                  pc_tag_we_o,
    output logic [TAG_WIDTH-1:0]  wb_tag_o,
    output logic                  wb_tag_valid_o,
    output logic                  exc_o,
    output logic [2:0]            exc_cause_o,
    output logic [MODE_WIDTH-1:0] exc_mode_o,
    input  logic                  exc_ack_i,
    input  logic                  cnt_clr_i,
    output logic [CNT_WIDTH-1:0]  viol_count_o
);

    localparam int ENTRIES = 2 ** MODE_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        PROP_OR     = 2'b00,
        PROP_AND    = 2'b01,
        PROP_CLEAR  = 2'b10,
        PROP_PASS_A = 2'b11
    } prop_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    logic [4:0]            table_q [ENTRIES];
    logic [4:0]            entry;
    prop_op_e              prop_op;
    logic                  chk_s1, chk_s2, chk_d;
    logic [TAG_WIDTH-1:0]  res_tag;
    logic                  fire, v_s1, v_s2, v_d, viol;

    state_e                state_q, state_d;
    logic [2:0]            cause_q, cause_d;
    logic [MODE_WIDTH-1:0] mode_q, mode_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0]  wb_tag_q, wb_tag_d;
    logic                  wb_valid_q, wb_valid_d;

    // NOTE: the table is built from reset flops rather than a RAM because every
    // entry must come out of reset as a defined OR/no-check policy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_we_i) begin
            table_q[cfg_addr_i] <= cfg_wdata_i;
        end
    end

    assign cfg_rdata_o = table_q[cfg_addr_i];
    assign entry       = table_q[mode_i];
    assign prop_op     = prop_op_e'(entry[4:3]);
    assign chk_s1      = entry[2];
    assign chk_s2      = entry[1];
    assign chk_d       = entry[0];

    always_comb begin
        res_tag = '0;
        case (prop_op)
            PROP_OR:     res_tag = tag_a_i | tag_b_i;
            PROP_AND:    res_tag = tag_a_i & tag_b_i;
            PROP_CLEAR:  res_tag = '0;
            PROP_PASS_A: res_tag = tag_a_i;
            default:     res_tag = '0;
        endcase
    end

    assign fire = ex_valid_i | branch_i;
    assign v_s1 = chk_s1 & (|(tag_a_i & tag_mask_i));
    assign v_s2 = chk_s2 & (|(tag_b_i & tag_mask_i));
    assign v_d  = chk_d  & (|(res_tag & tag_mask_i));
    assign viol = fire & (v_s1 | v_s2 | v_d);

    assign rf_tag_o     = res_tag;
    assign rf_tag_we_o  = ex_valid_i & rf_we_i & ~is_load_i;
    assign mem_tag_o    = res_tag;
    assign mem_tag_we_o = ex_valid_i & is_store_i;
    // A tagged jump target dominates the data-derived tag.
    assign pc_tag_o     = (tag_c_i != '0) ? tag_c_i : res_tag;
    assign pc_tag_we_o  = branch_i & branch_taken_i;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (viol) begin
                    state_d = ST_PEND;
                    cause_d = {v_s1, v_s2, v_d};
                    mode_d  = mode_i;
                end
            end
            ST_PEND: begin
                if (exc_ack_i) begin
                    if (viol) begin
                        cause_d = {v_s1, v_s2, v_d};
                        mode_d  = mode_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (viol && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        wb_tag_d   = wb_tag_q;
        wb_valid_d = wb_valid_q;
        if (ex_valid_i) begin
            wb_valid_d = is_load_i;
            if (is_load_i) begin
                wb_tag_d = tag_a_i;
            end
        end else if (wb_ready_i) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cause_q    <= '0;
            mode_q     <= '0;
            cnt_q      <= '0;
            wb_tag_q   <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            wb_tag_q   <= wb_tag_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign exc_o          = (state_q == ST_PEND);
    assign exc_cause_o    = cause_q;
    assign exc_mode_o     = mode_q;
    assign viol_count_o   = cnt_q;
    assign wb_tag_o       = wb_tag_q;
    assign wb_tag_valid_o = wb_valid_q;

endmodule

// File: tb/tb_riscv_dift_tag_unit.sv
// Self-checking bench for riscv_dift_tag_unit: table-driven combinational
// vectors through a scoreboard queue, plus hand sequences for stateful cases.
module tb_riscv_dift_tag_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we_i;
    logic [3:0] cfg_addr_i;
    logic [4:0] cfg_wdata_i;
    logic [4:0] cfg_rdata_o;
    logic [3:0] tag_mask_i, mode_i, tag_a_i, tag_b_i, tag_c_i;
    logic       rf_we_i, is_load_i, is_store_i, branch_i, branch_taken_i;
    logic       ex_valid_i, wb_ready_i, exc_ack_i, cnt_clr_i;
    logic [3:0] rf_tag_o, mem_tag_o, pc_tag_o, wb_tag_o;
    logic       rf_tag_we_o, mem_tag_we_o, pc_tag_we_o, wb_tag_valid_o, exc_o;
    logic [2:0] exc_cause_o;
    logic [3:0] exc_mode_o;
    logic [7:0] viol_count_o;

    // Second instance with a 2-bit counter for saturation checks.
    logic [4:0] s_cfg_rdata;
    logic [3:0] s_rf_tag, s_mem_tag, s_pc_tag, s_wb_tag, s_exc_mode;
    logic       s_rf_we, s_mem_we, s_pc_we, s_wb_valid, s_exc;
    logic [2:0] s_exc_cause;
    logic [1:0] s_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_dift_tag_unit dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_rdata_o(cfg_rdata_o), .tag_mask_i(tag_mask_i), .mode_i(mode_i),
        .tag_a_i(tag_a_i), .tag_b_i(tag_b_i), .tag_c_i(tag_c_i),
        .rf_we_i(rf_we_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
        .branch_i(branch_i), .branch_taken_i(branch_taken_i),
        .ex_valid_i(ex_valid_i), .wb_ready_i(wb_ready_i),
        .rf_tag_o(rf_tag_o), .rf_tag_we_o(rf_tag_we_o),
        .mem_tag_o(mem_tag_o), .mem_tag_we_o(mem_tag_we_o),
        .pc_tag_o(pc_tag_o), .pc_tag_we_o(pc_tag_we_o),
        .wb_tag_o(wb_tag_o), .wb_tag_valid_o(wb_tag_valid_o),
        .exc_o(exc_o), .exc_cause_o(exc_cause_o), .exc_mode_o(exc_mode_o),
        .exc_ack_i(exc_ack_i), .cnt_clr_i(cnt_clr_i), .viol_count_o(viol_count_o)
    );

    riscv_dift_tag_unit #(.TAG_WIDTH(4), .MODE_WIDTH(4), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_rdata_o(s_cfg_rdata), .tag_mask_i(tag_mask_i), .mode_i(mode_i),
        .tag_a_i(tag_a_i), .tag_b_i(tag_b_i), .tag_c_i(tag_c_i),
        .rf_we_i(rf_we_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
        .branch_i(branch_i), .branch_taken_i(branch_taken_i),
        .ex_valid_i(ex_valid_i), .wb_ready_i(wb_ready_i),
        .rf_tag_o(s_rf_tag), .rf_tag_we_o(s_rf_we),
        .mem_tag_o(s_mem_tag), .mem_tag_we_o(s_mem_we),
        .pc_tag_o(s_pc_tag), .pc_tag_we_o(s_pc_we),
        .wb_tag_o(s_wb_tag), .wb_tag_valid_o(s_wb_valid),
        .exc_o(s_exc), .exc_cause_o(s_exc_cause), .exc_mode_o(s_exc_mode),
        .exc_ack_i(exc_ack_i), .cnt_clr_i(cnt_clr_i), .viol_count_o(s_count)
    );

    typedef struct {
        logic [3:0] mode, a, b, c;
        logic       rf_we, ld, st, br, tk, ev;
        logic [3:0] exp_tag;
        logic       exp_rf_we, exp_mem_we;
        logic [3:0] exp_pc;
        logic       exp_pc_we, chk_pc;
    } vec_t;

    typedef struct {
        logic [3:0] tag;
        logic       rf_we, mem_we;
        logic [3:0] pc;
        logic       pc_we, chk_pc;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cfg_we_i = 0; cfg_addr_i = 0; cfg_wdata_i = 0; tag_mask_i = 0; mode_i = 0;
        tag_a_i = 0; tag_b_i = 0; tag_c_i = 0; rf_we_i = 0; is_load_i = 0;
        is_store_i = 0; branch_i = 0; branch_taken_i = 0; ex_valid_i = 0;
        wb_ready_i = 0; exc_ack_i = 0; cnt_clr_i = 0;
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic [4:0] data);
        cfg_we_i = 1; cfg_addr_i = addr; cfg_wdata_i = data;
        tick();
        cfg_we_i = 0;
    endtask

    task automatic set_op(input logic [3:0] m, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] mask, input logic ev);
        mode_i = m; tag_a_i = a; tag_b_i = b; tag_mask_i = mask; ex_valid_i = ev;
    endtask

    initial begin
        //          mode  a     b     c     rfwe ld st br tk ev  tag   rfwe mwe pc    pcwe chkpc
        vecs[0] = '{4'd3, 4'h1, 4'h8, 4'h0, 1, 0, 0, 0, 0, 1, 4'h9, 1, 0, 4'h9, 0, 0};
        vecs[1] = '{4'd6, 4'hC, 4'hA, 4'h0, 1, 0, 1, 0, 0, 1, 4'h8, 1, 1, 4'h8, 0, 0};
        vecs[2] = '{4'd7, 4'hF, 4'hF, 4'h0, 1, 1, 0, 0, 0, 1, 4'h0, 0, 0, 4'h0, 0, 0};
        vecs[3] = '{4'd8, 4'h5, 4'hA, 4'h0, 1, 0, 0, 0, 0, 1, 4'h5, 1, 0, 4'h5, 0, 0};
        vecs[4] = '{4'd0, 4'h2, 4'h4, 4'h0, 1, 0, 0, 1, 1, 0, 4'h6, 0, 0, 4'h6, 1, 1};
        vecs[5] = '{4'd0, 4'h2, 4'h4, 4'hA, 0, 0, 0, 1, 1, 0, 4'h6, 0, 0, 4'hA, 1, 1};
        vecs[6] = '{4'd0, 4'h2, 4'h4, 4'hA, 0, 0, 0, 1, 0, 0, 4'h6, 0, 0, 4'hA, 0, 0};
        vecs[7] = '{4'd3, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 1, 4'h0, 0, 1, 4'h0, 0, 0};

        clear_inputs();
        rst_n = 0;
        #12;
        check("reset_exc", exc_o, 0);
        check("reset_cause", exc_cause_o, 0);
        check("reset_mode", exc_mode_o, 0);
        check("reset_count", viol_count_o, 0);
        check("reset_wb_tag", wb_tag_o, 0);
        check("reset_wb_valid", wb_tag_valid_o, 0);
        cfg_addr_i = 4'd5;
        #1 check("reset_table5", cfg_rdata_o, 5'b00000);
        @(negedge clk);
        rst_n = 1;

        // Same-cycle write and read of one entry returns the old value.
        @(posedge clk); #1;
        cfg_we_i = 1; cfg_addr_i = 4'd5; cfg_wdata_i = 5'b01100;
        #1 check("cfg_same_cycle_old", cfg_rdata_o, 5'b00000);
        tick();
        cfg_we_i = 0;
        #1 check("cfg_after_write", cfg_rdata_o, 5'b01100);

        write_entry(4'd3, 5'b00000);
        write_entry(4'd6, 5'b01000);
        write_entry(4'd7, 5'b10000);
        write_entry(4'd8, 5'b11000);
        write_entry(4'd9, 5'b00001);
        cfg_addr_i = 4'd8;
        #1 check("cfg_read8", cfg_rdata_o, 5'b11000);

        // Table-driven combinational vectors through the scoreboard.
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            exp_t got;
            set_op(vecs[i].mode, vecs[i].a, vecs[i].b, 4'h0, vecs[i].ev);
            tag_c_i = vecs[i].c; rf_we_i = vecs[i].rf_we; is_load_i = vecs[i].ld;
            is_store_i = vecs[i].st; branch_i = vecs[i].br; branch_taken_i = vecs[i].tk;
            e = '{vecs[i].exp_tag, vecs[i].exp_rf_we, vecs[i].exp_mem_we,
                  vecs[i].exp_pc, vecs[i].exp_pc_we, vecs[i].chk_pc};
            sb.push_back(e);
            #1;
            got = sb.pop_front();
            check($sformatf("vec%0d_rf_tag", i), rf_tag_o, got.tag);
            check($sformatf("vec%0d_mem_tag", i), mem_tag_o, got.tag);
            check($sformatf("vec%0d_rf_we", i), rf_tag_we_o, got.rf_we);
            check($sformatf("vec%0d_mem_we", i), mem_tag_we_o, got.mem_we);
            check($sformatf("vec%0d_pc_we", i), pc_tag_we_o, got.pc_we);
            if (got.chk_pc) check($sformatf("vec%0d_pc_tag", i), pc_tag_o, got.pc);
            tick();
            clear_inputs();
        end
        check("vec_no_exc", exc_o, 0);
        check("vec_no_count", viol_count_o, 0);

        // Source-1 violation, second violation while pending, then acknowledge.
        set_op(4'd5, 4'h1, 4'h0, 4'h1, 1);
        tick();
        check("viol1_exc", exc_o, 1);
        check("viol1_cause", exc_cause_o, 3'b100);
        check("viol1_mode", exc_mode_o, 4'd5);
        check("viol1_count", viol_count_o, 1);
        set_op(4'd9, 4'h0, 4'h2, 4'hF, 1);
        tick();
        check("viol2_cause_kept", exc_cause_o, 3'b100);
        check("viol2_mode_kept", exc_mode_o, 4'd5);
        check("viol2_count", viol_count_o, 2);
        set_op(4'd0, 4'h0, 4'h0, 4'h0, 0);
        exc_ack_i = 1;
        tick();
        exc_ack_i = 0;
        check("ack_clears_exc", exc_o, 0);

        // Load tag into WB, hold across a stall, drain on wb_ready.
        set_op(4'd0, 4'h7, 4'h0, 4'h0, 1);
        is_load_i = 1;
        tick();
        clear_inputs();
        check("wb_tag", wb_tag_o, 4'h7);
        check("wb_valid", wb_tag_valid_o, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("wb_hold_tag%0d", k), wb_tag_o, 4'h7);
            check($sformatf("wb_hold_valid%0d", k), wb_tag_valid_o, 1);
        end
        wb_ready_i = 1;
        tick();
        wb_ready_i = 0;
        check("wb_drain_valid", wb_tag_valid_o, 0);

        // Saturation: clear, then 5 violating cycles; clear wins over increment.
        cnt_clr_i = 1;
        tick();
        cnt_clr_i = 0;
        check("cnt_cleared", viol_count_o, 0);
        set_op(4'd5, 4'h1, 4'h0, 4'h1, 1);
        for (int k = 0; k < 5; k++) tick();
        check("cnt8_five", viol_count_o, 5);
        check("cnt2_saturated", s_count, 2'd3);
        cnt_clr_i = 1;
        tick();
        cnt_clr_i = 0;
        check("cnt8_clr_wins", viol_count_o, 0);
        check("cnt2_clr_wins", s_count, 0);
        clear_inputs();
        exc_ack_i = 1;
        tick();
        exc_ack_i = 0;
        check("idle_before_ack_test", exc_o, 0);

        // Ack together with a d-only violation recaptures and stays pending.
        set_op(4'd5, 4'h1, 4'h0, 4'h1, 1);
        tick();
        check("pend_cause_s1", exc_cause_o, 3'b100);
        set_op(4'd9, 4'h0, 4'h2, 4'hF, 1);
        exc_ack_i = 1;
        tick();
        exc_ack_i = 0;
        clear_inputs();
        check("ack_viol_exc", exc_o, 1);
        check("ack_viol_cause", exc_cause_o, 3'b001);
        check("ack_viol_mode", exc_mode_o, 4'd9);

        // Asynchronous reset mid-pending, away from a clock edge.
        @(negedge clk);
        #2 rst_n = 0;
        cfg_addr_i = 4'd9;
        #1;
        check("arst_exc", exc_o, 0);
        check("arst_cause", exc_cause_o, 0);
        check("arst_mode", exc_mode_o, 0);
        check("arst_count", viol_count_o, 0);
        check("arst_wb_valid", wb_tag_valid_o, 0);
        check("arst_table9", cfg_rdata_o, 5'b00000);
        @(negedge clk);
        rst_n = 1;
        tick();
        check("post_reset_exc", exc_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_dift_tag_unit.md
# riscv_dift_tag_unit

Parametrised DIFT tag datapath for the EX stage: multi-bit tags, a programmable per-ALU-mode propagation/check policy table, an EX/WB tag pipeline register and a sticky tag-violation exception with saturating violation counter. Sits beside the ALU/multiplier in the EX stage. It replaces the fixed 1-bit propagation/check logic with a single configurable block that the CSR unit programs.

## Interface
- TAG_WIDTH, 4, bits per tag
- MODE_WIDTH, 4, ALU-mode code width; policy table has 2**MODE_WIDTH entries
- CNT_WIDTH, 8, violation counter width

- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- cfg_we_i  in  1  policy table write strobe
- cfg_addr_i  in  MODE_WIDTH  table entry index for read and write
- cfg_wdata_i  in  5  {prop_op[1:0], chk_s1, chk_s2, chk_d}
- cfg_rdata_o  out  5  entry at cfg_addr_i (combinational)
- tag_mask_i  in  TAG_WIDTH  tag bits participating in checks
- mode_i  in  MODE_WIDTH  ALU mode of the EX instruction
- tag_a_i, tag_b_i, tag_c_i  in  TAG_WIDTH  operand tags (c = jump target)
- rf_we_i, is_load_i, is_store_i, branch_i, branch_taken_i  in  1  instruction class
- ex_valid_i, wb_ready_i  in  1  EX/WB handshake from EX stage
- rf_tag_o  out  TAG_WIDTH;  rf_tag_we_o  out  1  register-file tag write
- mem_tag_o  out  TAG_WIDTH;  mem_tag_we_o  out  1  store data tag
- pc_tag_o  out  TAG_WIDTH;  pc_tag_we_o  out  1  PC tag update
- wb_tag_o  out  TAG_WIDTH;  wb_tag_valid_o  out  1  load-address tag to WB
- exc_o  out  1  tag violation pending
- exc_cause_o  out  3  {s1, s2, d} violations captured
- exc_mode_o  out  MODE_WIDTH  mode of the faulting instruction
- exc_ack_i  in  1  exception acknowledge from controller
- cnt_clr_i  in  1  clear violation counter
- viol_count_o  out  CNT_WIDTH  saturating violation count

## Operation
- Policy entry e = table[mode_i]. prop_op: 00 OR (a|b), 01 AND (a&b), 10 CLEAR (0), 11 PASS_A (a). Result tag r = prop_op(tag_a_i, tag_b_i).
- fire = ex_valid_i | branch_i.
- Violations: v_s1 = chk_s1 & |(tag_a_i & tag_mask_i); v_s2 = chk_s2 & |(tag_b_i & tag_mask_i); v_d = chk_d & |(r & tag_mask_i); viol = fire & (v_s1|v_s2|v_d).
- rf_tag_o = r; rf_tag_we_o = ex_valid_i & rf_we_i & ~is_load_i.
- mem_tag_o = r; mem_tag_we_o = ex_valid_i & is_store_i.
- Branch: pc_tag_we_o = branch_i & branch_taken_i. pc_tag_o = (tag_c_i != 0) ? tag_c_i : r. Not taken: pc_tag_we_o = 0, PC tag unchanged.
- WB register: if ex_valid_i: wb_tag_valid_o <= is_load_i; if is_load_i, wb_tag_o <= tag_a_i. Else if wb_ready_i: wb_tag_valid_o <= 0. Otherwise hold.
- Exception FSM, states IDLE, PEND:
  - IDLE: viol -> PEND; latch exc_cause_o = {v_s1,v_s2,v_d}, exc_mode_o = mode_i.
  - PEND: exc_o = 1. New violations do not overwrite cause/mode. exc_ack_i & ~viol -> IDLE. exc_ack_i & viol -> stay PEND, recapture cause/mode. exc_ack_i in IDLE is ignored.
- Counter: +1 per cycle with viol, saturates at 2**CNT_WIDTH-1. cnt_clr_i wins over an increment in the same cycle, giving 0.
- Table write: entry updated at clock edge and used from the next cycle. A same-cycle write and lookup of one entry returns the old entry.

## Timing
- Reset: table entries all 5'b00000 (OR, no checks); wb_tag_o = 0, wb_tag_valid_o = 0, FSM IDLE, exc_o = 0, exc_cause_o = 0, exc_mode_o = 0, viol_count_o = 0.
- Combinational outputs, 0-cycle latency from inputs: rf_tag*, mem_tag*, pc_tag*, cfg_rdata_o.
- exc_o, exc_cause_o, exc_mode_o, viol_count_o and wb_tag* have 1-cycle latency after the triggering edge.
- Async reset mid-PEND clears exc_o immediately. Mid-stall (ex_valid_i = 0, wb_ready_i = 0) the WB tag register holds.

## Test plan
- Table entry 3 = {00,0,0,0}; mode 3, a=4'h1, b=4'h8, rf_we, ex_valid -> rf_tag_o=4'h9, rf_tag_we_o=1, no exception.
- Entry 5 = {01,1,0,0}, mask 4'h1, a=4'h1, ex_valid -> next cycle exc_o=1, cause=3'b100, mode=5, count=1. Second violation while PEND -> cause unchanged, count=2. Ack -> exc_o=0.
- Branch taken, c=4'h0, entry OR, a=2, b=4 -> pc_tag_o=4'h6, we=1. c=4'hA -> pc_tag_o=4'hA. Not taken -> pc_tag_we_o=0.
- Load, a=4'h7, ex_valid -> wb_tag_o=7, valid=1 next cycle. Then ex_valid=0, wb_ready=0 for 3 cycles -> holds. wb_ready=1 -> valid=0.
- CNT_WIDTH=2: 5 violating cycles -> count 3 (saturated). cnt_clr_i together with viol -> 0.
- exc_ack_i together with a new violation (d only) in PEND -> stays PEND, cause=3'b001. Assert rst_n low mid-PEND -> all outputs at reset values immediately.
